// File: rtl/layer_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_stream_pkg
// Brief    : Shared types and default widths for the layer stream packers.
// Revision : 1.0 - initial release
// ============================================================================
package layer_stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_CHANNELS   = 32;
    localparam int PACKED_WIDTH       = DEFAULT_DATA_WIDTH * DEFAULT_CHANNELS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_raster_counter.sv
`default_nettype none
// ============================================================================
// Module   : pixel_raster_counter
// Brief    : Column/row raster position with wrap, last-pixel and border flags.
//            Border logic exists only when PACKER_PAD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_raster_counter #(
    parameter int IMG_SIZE = 104,
    parameter int POS_W    = $clog2(IMG_SIZE + 2)
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear,
    input  logic advance,
`ifdef PACKER_PAD_EN
    output logic border,
    output logic row_end,
`endif
    output logic last_pixel
);

`ifdef PACKER_PAD_EN
    localparam int EXTENT = IMG_SIZE + 2;
`else
    localparam int EXTENT = IMG_SIZE;
`endif
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(EXTENT - 1);

    logic [POS_W-1:0] col_q, col_d;
    logic [POS_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            if (col_q == LAST_POS) begin
                col_d = '0;
                row_d = (row_q == LAST_POS) ? '0 : row_q + POS_W'(1);
            end else begin
                col_d = col_q + POS_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign last_pixel = (col_q == LAST_POS) && (row_q == LAST_POS);

`ifdef PACKER_PAD_EN
    assign border  = (col_q == '0) || (col_q == LAST_POS) ||
                     (row_q == '0) || (row_q == LAST_POS);
    // Padded coordinate IMG_SIZE is the last interior column of a row
    assign row_end = (col_q == POS_W'(IMG_SIZE));
`endif

endmodule
`default_nettype wire

// File: rtl/layer_4_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : layer_4_stream_packer
// Brief    : Packs CHANNELS serial values into one word per pixel; optional
//            zero border ring when PACKER_PAD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module layer_4_stream_packer
    import layer_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CHANNELS   = DEFAULT_CHANNELS,
    parameter int IMG_SIZE   = 104
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           frame_start,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic                           valid_in,
    output logic                           ready_out,
    output logic [DATA_WIDTH*CHANNELS-1:0] data_out,
    output logic                           valid_out,
    output logic                           frame_done
);

    localparam int               WORD_W  = DATA_WIDTH * CHANNELS;
    localparam int               STAGE_W = WORD_W - DATA_WIDTH;
    localparam int               CH_W    = $clog2(CHANNELS);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CHANNELS - 1);

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
    logic [STAGE_W-1:0]  stage_q, stage_d;
    logic [WORD_W-1:0]   data_out_q, data_out_d;
    logic                valid_out_q, valid_out_d;
    logic                frame_done_q, frame_done_d;
    logic                ready_out_q, ready_out_d;

    logic rc_clear, rc_advance, last_pixel;
`ifdef PACKER_PAD_EN
    logic border, row_end;
`endif

    pixel_raster_counter #(
        .IMG_SIZE (IMG_SIZE)
    ) u_raster (
        .Clk        (Clk),
        .Rst        (Rst),
        .clear      (rc_clear),
        .advance    (rc_advance),
`ifdef PACKER_PAD_EN
        .border     (border),
        .row_end    (row_end),
`endif
        .last_pixel (last_pixel)
    );

    always_comb begin
        state_d      = state_q;
        ch_cnt_d     = ch_cnt_q;
        stage_d      = stage_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        ready_out_d  = ready_out_q;
        rc_clear     = 1'b0;
        rc_advance   = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    rc_clear = 1'b1;
                    ch_cnt_d = '0;
`ifdef PACKER_PAD_EN
                    state_d     = PAD;
                    ready_out_d = 1'b0;
`else
                    state_d     = FILL;
                    ready_out_d = 1'b1;
`endif
                end
            end

            FILL: begin
                if (valid_in && ready_out_q) begin
                    if (ch_cnt_q == CH_LAST) begin
                        // Final lane bypasses staging so the word leaves next cycle
                        data_out_d  = {data_in, stage_q};
                        valid_out_d = 1'b1;
                        ch_cnt_d    = '0;
                        rc_advance  = 1'b1;
`ifdef PACKER_PAD_EN
                        if (row_end) begin
                            state_d     = PAD;
                            ready_out_d = 1'b0;
                        end
`else
                        if (last_pixel) begin
                            frame_done_d = 1'b1;
                            state_d      = IDLE;
                            ready_out_d  = 1'b0;
                        end
`endif
                    end else begin
                        for (int k = 0; k < CHANNELS - 1; k++) begin
                            if (ch_cnt_q == CH_W'(k)) begin
                                stage_d[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
                            end
                        end
                        ch_cnt_d = ch_cnt_q + CH_W'(1);
                    end
                end
            end

`ifdef PACKER_PAD_EN
            PAD: begin
                if (border) begin
                    data_out_d  = '0;
                    valid_out_d = 1'b1;
                    if (last_pixel) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        rc_advance = 1'b1;
                    end
                end else begin
                    state_d     = FILL;
                    ready_out_d = 1'b1;
                end
            end
`endif

            default: begin
                state_d     = IDLE;
                ready_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= IDLE;
            ch_cnt_q     <= '0;
            stage_q      <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            ready_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_cnt_q     <= ch_cnt_d;
            stage_q      <= stage_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
            ready_out_q  <= ready_out_d;
        end
    end

    assign ready_out  = ready_out_q;
    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_4_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_4_stream_packer
// Brief    : Directed self-checking bench; dut_a has a 1x1 image, dut_b 2x2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_4_stream_packer;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           fs_a, fs_b;
    logic [31:0]    data_in;
    logic           valid_in;
    logic           ready_a, valid_a, done_a;
    logic           ready_b, valid_b, done_b;
    logic [1023:0]  dout_a, dout_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    layer_4_stream_packer #(.DATA_WIDTH(32), .CHANNELS(32), .IMG_SIZE(1)) dut_a (
        .Clk(Clk), .Rst(Rst), .frame_start(fs_a), .data_in(data_in),
        .valid_in(valid_in), .ready_out(ready_a), .data_out(dout_a),
        .valid_out(valid_a), .frame_done(done_a)
    );

    layer_4_stream_packer #(.DATA_WIDTH(32), .CHANNELS(32), .IMG_SIZE(2)) dut_b (
        .Clk(Clk), .Rst(Rst), .frame_start(fs_b), .data_in(data_in),
        .valid_in(valid_in), .ready_out(ready_b), .data_out(dout_b),
        .valid_out(valid_b), .frame_done(done_b)
    );

    function automatic logic [1023:0] make_word(input logic [31:0] base);
        logic [1023:0] w;
        for (int k = 0; k < 32; k++) w[k*32 +: 32] = base + 32'(k);
        return w;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        Rst = 1'b0; valid_in = 1'b0; fs_a = 1'b0; fs_b = 1'b0;
        tick();
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        Rst = 1'b0; fs_a = 1'b0; fs_b = 1'b0; valid_in = 1'b0; data_in = '0;
        tick(); tick();
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_ready_a got=%b exp=0", ready_a); end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a got=%b exp=0", valid_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done_a got=%b exp=0", done_a); end
        n_checks++; if (dout_a !== '0) begin n_fail++; $display("FAIL reset_dout_a got=%h exp=0", dout_a[63:0]); end
        n_checks++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL reset_ready_b got=%b exp=0", ready_b); end
        n_checks++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b got=%b exp=0", valid_b); end
        n_checks++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL reset_done_b got=%b exp=0", done_b); end
        n_checks++; if (dout_b !== '0) begin n_fail++; $display("FAIL reset_dout_b got=%h exp=0", dout_b[63:0]); end
        Rst = 1'b1;
    endtask

`ifndef PACKER_PAD_EN
    task automatic test_single_pixel();
        logic early = 1'b0;
        fs_a = 1'b1; tick(); fs_a = 1'b0;
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL single_ready_rise got=%b exp=1", ready_a); end
        for (int k = 0; k < 32; k++) begin
            data_in = 32'h3f80_0000 + 32'(k); valid_in = 1'b1;
            tick();
            if (k < 31 && valid_a) early = 1'b1;
        end
        valid_in = 1'b0;
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b exp=0", early); end
        n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", valid_a); end
        n_checks++; if (dout_a !== make_word(32'h3f80_0000)) begin n_fail++; $display("FAIL single_word got=%h exp=%h", dout_a[63:0], make_word(32'h3f80_0000)); end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL single_done got=%b exp=1", done_a); end
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL single_ready_drop got=%b exp=0", ready_a); end
        tick();
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL single_valid_width got=%b exp=0", valid_a); end
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL single_ready_after got=%b exp=0", ready_a); end
    endtask

    task automatic test_gapped();
        int xfer = 0, pulses = 0, dones = 0;
        logic acc, prev = 1'b0, width_bad = 1'b0;
        fs_b = 1'b1; tick(); fs_b = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            valid_in = ((cyc % 2) == 0) && (xfer < 128);
            data_in  = 32'h1000_0000 + 32'((xfer / 32) * 256 + (xfer % 32));
            acc = valid_in && ready_b;
            tick();
            if (acc) xfer++;
            if (valid_b) begin
                n_checks++;
                if (dout_b !== make_word(32'h1000_0000 + 32'(pulses * 256))) begin
                    n_fail++; $display("FAIL gapped_word%0d got=%h exp=%h", pulses, dout_b[63:0], make_word(32'h1000_0000 + 32'(pulses * 256)));
                end
                n_checks++;
                if (done_b !== (pulses == 3)) begin
                    n_fail++; $display("FAIL gapped_done%0d got=%b exp=%b", pulses, done_b, pulses == 3);
                end
                if (prev) width_bad = 1'b1;
                pulses++;
            end
            if (done_b) dones++;
            prev = valid_b;
            if (dones > 0 && !valid_b) break;
        end
        valid_in = 1'b0;
        n_checks++; if (pulses !== 4) begin n_fail++; $display("FAIL gapped_pulses got=%0d exp=4", pulses); end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL gapped_dones got=%0d exp=1", dones); end
        n_checks++; if (width_bad !== 1'b0) begin n_fail++; $display("FAIL gapped_pulse_width got=%b exp=0", width_bad); end
        n_checks++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL gapped_ready_end got=%b exp=0", ready_b); end
    endtask

    task automatic test_mid_reset();
        fs_b = 1'b1; tick(); fs_b = 1'b0;
        for (int k = 0; k < 17; k++) begin
            data_in = 32'hdead_0000 + 32'(k); valid_in = 1'b1; tick();
        end
        valid_in = 1'b0; Rst = 1'b0;
        tick();
        n_checks++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", valid_b); end
        n_checks++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got=%b exp=0", ready_b); end
        n_checks++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", done_b); end
        n_checks++; if (dout_b !== '0) begin n_fail++; $display("FAIL midrst_dout got=%h exp=0", dout_b[63:0]); end
        Rst = 1'b1;
        fs_b = 1'b1; tick(); fs_b = 1'b0;
        for (int k = 0; k < 32; k++) begin
            data_in = 32'h4000_0000 + 32'(k); valid_in = 1'b1; tick();
        end
        valid_in = 1'b0;
        n_checks++; if (valid_b !== 1'b1) begin n_fail++; $display("FAIL midrst_clean_valid got=%b exp=1", valid_b); end
        n_checks++; if (dout_b !== make_word(32'h4000_0000)) begin n_fail++; $display("FAIL midrst_clean_word got=%h exp=%h", dout_b[63:0], make_word(32'h4000_0000)); end
        n_checks++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL midrst_clean_done got=%b exp=0", done_b); end
        pulse_reset();
    endtask

    task automatic test_ignored();
        logic bad_rdy = 1'b0, bad_vld = 1'b0, early = 1'b0;
        for (int c = 0; c < 40; c++) begin
            data_in = 32'hbad0_0000 + 32'(c); valid_in = 1'b1;
            tick();
            if (ready_b) bad_rdy = 1'b1;
            if (valid_b) bad_vld = 1'b1;
        end
        valid_in = 1'b0;
        n_checks++; if (bad_rdy !== 1'b0) begin n_fail++; $display("FAIL ign_idle_ready got=%b exp=0", bad_rdy); end
        n_checks++; if (bad_vld !== 1'b0) begin n_fail++; $display("FAIL ign_idle_valid got=%b exp=0", bad_vld); end
        fs_b = 1'b1; tick(); fs_b = 1'b0;
        for (int k = 0; k < 32; k++) begin
            data_in = 32'h5000_0000 + 32'(k); valid_in = 1'b1;
            fs_b = (k == 10);
            tick();
            if (k < 31 && valid_b) early = 1'b1;
        end
        fs_b = 1'b0; valid_in = 1'b0;
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL ign_fill_early got=%b exp=0", early); end
        n_checks++; if (valid_b !== 1'b1) begin n_fail++; $display("FAIL ign_fill_valid got=%b exp=1", valid_b); end
        n_checks++; if (dout_b !== make_word(32'h5000_0000)) begin n_fail++; $display("FAIL ign_fill_word got=%h exp=%h", dout_b[63:0], make_word(32'h5000_0000)); end
        pulse_reset();
    endtask

    task automatic test_back_to_back();
        fs_a = 1'b1; tick(); fs_a = 1'b0;
        for (int k = 0; k < 32; k++) begin
            data_in = 32'h1111_0000 + 32'(k); valid_in = 1'b1; tick();
        end
        valid_in = 1'b0;
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got=%b exp=1", done_a); end
        n_checks++; if (dout_a !== make_word(32'h1111_0000)) begin n_fail++; $display("FAIL b2b_first_word got=%h exp=%h", dout_a[63:0], make_word(32'h1111_0000)); end
        fs_a = 1'b1; tick(); fs_a = 1'b0;
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", ready_a); end
        for (int k = 0; k < 32; k++) begin
            data_in = 32'h2222_0000 + 32'(k); valid_in = 1'b1; tick();
        end
        valid_in = 1'b0;
        n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got=%b exp=1", valid_a); end
        n_checks++; if (dout_a !== make_word(32'h2222_0000)) begin n_fail++; $display("FAIL b2b_second_word got=%h exp=%h", dout_a[63:0], make_word(32'h2222_0000)); end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got=%b exp=1", done_a); end
    endtask
`else
    task automatic test_pad();
        int xfer = 0, words = 0, first = 0, r, c;
        logic acc, rdy_bad = 1'b0, seq_bad = 1'b0, done_bad = 1'b0;
        logic [1023:0] exp;
        fs_b = 1'b1; tick(); fs_b = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            valid_in = (xfer < 128);
            data_in  = 32'h6000_0000 + 32'((xfer / 32) * 256 + (xfer % 32));
            acc = valid_in && ready_b;
            tick();
            if (acc) xfer++;
            if (valid_b) begin
                r = words / 4; c = words % 4;
                if (r == 0 || r == 3 || c == 0 || c == 3) exp = '0;
                else exp = make_word(32'h6000_0000 + 32'(((r - 1) * 2 + (c - 1)) * 256));
                n_checks++;
                if (dout_b !== exp) begin
                    n_fail++; $display("FAIL pad_word%0d got=%h exp=%h", words, dout_b[63:0], exp[63:0]);
                end
                if (words < 5) begin
                    if (ready_b !== 1'b0) rdy_bad = 1'b1;
                    if (words == 0) first = cyc;
                    else if (cyc != first + words) seq_bad = 1'b1;
                end
                if (done_b !== (words == 15)) done_bad = 1'b1;
                words++;
                if (words == 16) break;
            end
        end
        valid_in = 1'b0;
        n_checks++; if (words !== 16) begin n_fail++; $display("FAIL pad_words got=%0d exp=16", words); end
        n_checks++; if (rdy_bad !== 1'b0) begin n_fail++; $display("FAIL pad_border_ready got=%b exp=0", rdy_bad); end
        n_checks++; if (seq_bad !== 1'b0) begin n_fail++; $display("FAIL pad_border_consecutive got=%b exp=0", seq_bad); end
        n_checks++; if (done_bad !== 1'b0) begin n_fail++; $display("FAIL pad_done_placement got=%b exp=0", done_bad); end
        tick();
        n_checks++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL pad_after_valid got=%b exp=0", valid_b); end
    endtask
`endif

    initial begin
        Rst = 1'b0; fs_a = 1'b0; fs_b = 1'b0; valid_in = 1'b0; data_in = '0;
        test_reset();
`ifndef PACKER_PAD_EN
        test_single_pixel();
        test_gapped();
        test_mid_reset();
        test_ignored();
        test_back_to_back();
`else
        test_pad();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
